sr_request_conditioner: RTL and testbench



---
 rtl/sr_request_conditioner.sv | 106 ++++++++++
 tb/tb_sr_request_conditioner.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sr_request_conditioner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : sr_request_conditioner
// Description : Synchronizes and debounces raw set/clear requests and turns
//               their rising edges into clean, mutually exclusive S/R pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_request_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3,
    parameter int CONFLICT_MODE   = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_req,
    input  logic rst_req,
    input  logic clr_err,
    output logic S,
    output logic R,
    output logic q_model,
    output logic conflict,
    output logic err_sticky
);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2**CNT_W) - 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must lie in 1..2**CNT_W-1");
    end
    if (CONFLICT_MODE < 0 || CONFLICT_MODE > 2) begin : g_bad_mode
        $error("CONFLICT_MODE must be 0, 1 or 2");
    end

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Channel 0 carries the set request, channel 1 the clear request.
    logic [1:0]       req;
    logic [1:0]       s1;
    logic [1:0]       s2;
    logic [1:0]       deb;
    logic [1:0]       deb_d;
    logic [CNT_W-1:0] cnt [2];
    logic             set_edge;
    logic             rst_edge;
    logic             s_nxt;
    logic             r_nxt;

    assign req      = {rst_req, set_req};
    assign set_edge = deb[0] & ~deb_d[0];
    assign rst_edge = deb[1] & ~deb_d[1];

    always_comb begin
        s_nxt = set_edge & ~rst_edge;
        r_nxt = rst_edge & ~set_edge;
        if (set_edge && rst_edge) begin
            if (CONFLICT_MODE == 0) begin
                r_nxt = 1'b1;
            end else if (CONFLICT_MODE == 1) begin
                s_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1         <= '0;
            s2         <= '0;
            deb        <= '0;
            deb_d      <= '0;
            cnt[0]     <= '0;
            cnt[1]     <= '0;
            S          <= 1'b0;
            R          <= 1'b0;
            q_model    <= 1'b0;
            conflict   <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            s1    <= req;
            s2    <= s1;
            deb_d <= deb;
            for (int ch = 0; ch < 2; ch++) begin
                // A level is accepted only after it differs for DEBOUNCE_CYCLES straight edges.
                if (s2[ch] != deb[ch]) begin
                    if (cnt[ch] == DEB_LAST) begin
                        deb[ch] <= s2[ch];
                        cnt[ch] <= '0;
                    end else begin
                        cnt[ch] <= cnt[ch] + 1'b1;
                    end
                end else begin
                    cnt[ch] <= '0;
                end
            end
            S        <= s_nxt;
            R        <= r_nxt;
            conflict <= set_edge & rst_edge;
            if (s_nxt) begin
                q_model <= 1'b1;
            end else if (r_nxt) begin
                q_model <= 1'b0;
            end
            err_sticky <= conflict | (err_sticky & ~clr_err);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sr_request_conditioner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_sr_request_conditioner
// Description : Self-checking bench; one DUT per conflict policy, all sharing
//               the same stimulus and compared against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_request_conditioner;

    localparam int D  = 4;
    localparam int CW = 3;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       set_req = 1'b0;
    logic       rst_req = 1'b0;
    logic       clr_err = 1'b0;
    logic [2:0] dut_s;
    logic [2:0] dut_r;
    logic [2:0] dut_q;
    logic [2:0] dut_c;
    logic [2:0] dut_e;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar m = 0; m < 3; m++) begin : g_dut
        sr_request_conditioner #(
            .DEBOUNCE_CYCLES(D),
            .CNT_W          (CW),
            .CONFLICT_MODE  (m)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .set_req   (set_req),
            .rst_req   (rst_req),
            .clr_err   (clr_err),
            .S         (dut_s[m]),
            .R         (dut_r[m]),
            .q_model   (dut_q[m]),
            .conflict  (dut_c[m]),
            .err_sticky(dut_e[m])
        );
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a request level is accepted once the last D synchronized
    // samples all disagree with the accepted level; accepted rising edges become
    // pulses one cycle later, resolved per policy.
    logic [31:0] hist [2];
    bit          mdeb [2];
    bit          ev   [2];
    bit          es   [3];
    bit          er   [3];
    bit          ec   [3];
    bit          eq   [3];
    bit          ee   [3];
    bit          x;
    bit          all_diff;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int ch = 0; ch < 2; ch++) begin
                hist[ch] = '0;
                mdeb[ch] = 1'b0;
                ev[ch]   = 1'b0;
            end
            for (int m = 0; m < 3; m++) begin
                es[m] = 1'b0; er[m] = 1'b0; ec[m] = 1'b0; eq[m] = 1'b0; ee[m] = 1'b0;
            end
        end else begin
            for (int m = 0; m < 3; m++) begin
                ee[m] = ec[m] | (ee[m] & ~clr_err);
                es[m] = ev[0] & (~ev[1] | (m == 1));
                er[m] = ev[1] & (~ev[0] | (m == 0));
                ec[m] = ev[0] & ev[1];
                if (es[m]) eq[m] = 1'b1;
                else if (er[m]) eq[m] = 1'b0;
            end
            for (int ch = 0; ch < 2; ch++) begin
                x        = (ch == 0) ? set_req : rst_req;
                hist[ch] = {hist[ch][30:0], x};
                all_diff = 1'b1;
                for (int j = 2; j <= D + 1; j++) begin
                    if (hist[ch][j] == mdeb[ch]) all_diff = 1'b0;
                end
                ev[ch] = all_diff & ~mdeb[ch];
                if (all_diff) mdeb[ch] = ~mdeb[ch];
            end
        end
        #1;
        for (int m = 0; m < 3; m++) begin
            check_value($sformatf("S_m%0d", m), dut_s[m], es[m]);
            check_value($sformatf("R_m%0d", m), dut_r[m], er[m]);
            check_value($sformatf("q_model_m%0d", m), dut_q[m], eq[m]);
            check_value($sformatf("conflict_m%0d", m), dut_c[m], ec[m]);
            check_value($sformatf("err_sticky_m%0d", m), dut_e[m], ee[m]);
            check_value($sformatf("s_and_r_m%0d", m), dut_s[m] & dut_r[m], 0);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        idle(3);
        check_value("reset_S", dut_s, 0);
        check_value("reset_R", dut_r, 0);
        check_value("reset_q", dut_q, 0);
        check_value("reset_err", dut_e, 0);
        rst_n = 1'b1;
        idle(1);

        // Single set request: pulse between edges D+2 and D+3.
        set_req = 1'b1;
        idle(D + 2);
        check_value("set_before", dut_s[0], 0);
        idle(1);
        check_value("set_pulse", dut_s[0], 1);
        check_value("set_q", dut_q[0], 1);
        check_value("set_no_r", dut_r[0], 0);
        idle(1);
        check_value("set_after", dut_s[0], 0);
        set_req = 1'b0;
        idle(10);

        // Short clear glitch is rejected, a held clear is accepted.
        rst_req = 1'b1;
        idle(D - 1);
        rst_req = 1'b0;
        idle(10);
        check_value("glitch_q", dut_q[0], 1);
        rst_req = 1'b1;
        idle(10);
        check_value("held_clear_q", dut_q[0], 0);
        rst_req = 1'b0;
        idle(10);

        // Simultaneous requests resolved per policy (modes 0,1,2 on bits 0,1,2).
        set_req = 1'b1;
        rst_req = 1'b1;
        idle(D + 2);
        check_value("conf_before", dut_c, 0);
        idle(1);
        check_value("conf_S", dut_s, 3'b010);
        check_value("conf_R", dut_r, 3'b001);
        check_value("conf_flag", dut_c, 3'b111);
        idle(1);
        check_value("conf_done", dut_c, 0);
        check_value("conf_err", dut_e, 3'b111);
        check_value("conf_q", dut_q, 3'b010);
        set_req = 1'b0;
        rst_req = 1'b0;
        idle(10);

        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        check_value("clr_err", dut_e, 0);

        // Clear in the same cycle as a new conflict: the conflict wins.
        set_req = 1'b1;
        rst_req = 1'b1;
        idle(D + 3);
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        check_value("clr_vs_conf", dut_e, 3'b111);
        set_req = 1'b0;
        rst_req = 1'b0;
        idle(10);

        // Reset mid-debounce with the request held across release.
        set_req = 1'b1;
        idle(2);
        rst_n = 1'b0;
        #1;
        check_value("mid_rst_S", dut_s, 0);
        check_value("mid_rst_q", dut_q, 0);
        check_value("mid_rst_err", dut_e, 0);
        idle(2);
        rst_n = 1'b1;
        idle(D + 2);
        check_value("rel_before", dut_s, 0);
        idle(1);
        check_value("rel_pulse", dut_s, 3'b111);
        check_value("rel_q", dut_q, 3'b111);
        set_req = 1'b0;
        idle(10);

        // Random traffic, with periodic bursts of fast toggling.
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if ((i % 2000) < 100) begin
                if ($urandom_range(1) == 0) set_req = ~set_req;
                if ($urandom_range(1) == 0) rst_req = ~rst_req;
            end else begin
                if ($urandom_range(7) == 0) set_req = ~set_req;
                if ($urandom_range(7) == 0) rst_req = ~rst_req;
            end
            clr_err = ($urandom_range(31) == 0);
        end
        set_req = 1'b0;
        rst_req = 1'b0;
        clr_err = 1'b0;
        idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
